// File: rtl/calc_pkg.sv
// Shared widths, command record and scheduler state encoding for the calc result path.
package calc_pkg;

   localparam int DTYPE_W = 4;
   localparam int OP_W    = 5;
   localparam int SRC_W   = 16;
   localparam int CMD_W   = DTYPE_W + OP_W + 2 * SRC_W;

   typedef struct packed {
      logic [DTYPE_W-1:0] dtype;
      logic [OP_W-1:0]    operator;
      logic [SRC_W-1:0]   src1;
      logic [SRC_W-1:0]   src2;
   } cmd_t;

   // Encoding is visible on fsm_state: 0 idle, 1 issue, 2 wait for ALU, 3 wait for TX.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ALU = 2'd2,
      ST_WAIT_TX  = 2'd3
   } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is taken only when a pop
// happens in the same cycle.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 41
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/calc_sched.sv
// Command scheduler: queues parsed commands and feeds them one at a time to the
// ALU, waiting for the encoder to finish each result before the next issue.
module calc_sched
   import calc_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     parser_done,
   input  logic [DTYPE_W-1:0]       dtype,
   input  logic [OP_W-1:0]          operator,
   input  logic [SRC_W-1:0]         src1,
   input  logic [SRC_W-1:0]         src2,
   input  logic                     alu_done,
   input  logic                     enc_done,
   output logic                     alu_start,
   output logic [DTYPE_W-1:0]       alu_dtype,
   output logic [OP_W-1:0]          alu_operator,
   output logic [SRC_W-1:0]         alu_src1,
   output logic [SRC_W-1:0]         alu_src2,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     ovf,
   output logic                     tmo,
   output logic [7:0]               drop_cnt,
   output logic [1:0]               fsm_state
);

   // All strobes (parser_done, alu_done, enc_done, alu_start, ovf, tmo) are
   // single-cycle pulses with no back-pressure: a strobe arriving in a state
   // that does not expect it is ignored, never remembered.

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t          state;
   state_t          state_next;
   logic [WD_W-1:0] wd;
   cmd_t            cmd_in;
   cmd_t            head;
   logic            pop;
   logic            full;
   logic            empty;
   logic            drop;
   logic            expire;
   logic            load;

   assign cmd_in = '{dtype: dtype, operator: operator, src1: src1, src2: src2};
   assign pop    = (state == ST_ISSUE);
   assign drop   = parser_done && full && !pop;
   assign expire = (state == ST_WAIT_ALU) && (wd == WD_LAST) && !alu_done;
   // Fields are captured on entry to ISSUE so they are valid while alu_start is high.
   assign load   = (state == ST_IDLE) && !empty;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (parser_done),
      .pop   (pop),
      .din   (cmd_in),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (!empty) state_next = ST_ISSUE;
         ST_ISSUE:    state_next = ST_WAIT_ALU;
         ST_WAIT_ALU: begin
            if (alu_done)    state_next = ST_WAIT_TX;
            else if (expire) state_next = ST_IDLE;
         end
         ST_WAIT_TX:  if (enc_done) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      alu_start = 1'b0;
      busy      = 1'b0;
      tmo       = 1'b0;
      fsm_state = state;
      if (state == ST_ISSUE) alu_start = 1'b1;
      if (state != ST_IDLE)  busy      = 1'b1;
      if (expire)            tmo       = 1'b1;
   end

   // Watchdog runs only while waiting for the ALU and restarts from zero on every exit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wd <= '0;
      end else if (state == ST_WAIT_ALU && !alu_done && !expire) begin
         wd <= wd + 1'b1;
      end else begin
         wd <= '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         alu_dtype    <= '0;
         alu_operator <= '0;
         alu_src1     <= '0;
         alu_src2     <= '0;
      end else if (load) begin
         alu_dtype    <= head.dtype;
         alu_operator <= head.operator;
         alu_src1     <= head.src1;
         alu_src2     <= head.src2;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         ovf <= drop;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_calc_sched.sv
// Directed bench for calc_sched: inputs change on the falling edge, outputs are
// checked on the falling edge (or a few ns after an asynchronous reset).
module tb_calc_sched;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        parser_done = 1'b0;
   logic [3:0]  dtype = '0;
   logic [4:0]  operator = '0;
   logic [15:0] src1 = '0;
   logic [15:0] src2 = '0;
   logic        alu_done = 1'b0;
   logic        enc_done = 1'b0;
   logic        alu_start;
   logic [3:0]  alu_dtype;
   logic [4:0]  alu_operator;
   logic [15:0] alu_src1;
   logic [15:0] alu_src2;
   logic        busy;
   logic [2:0]  fifo_level;
   logic        ovf;
   logic        tmo;
   logic [7:0]  drop_cnt;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   int ovf_seen = 0;

   calc_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .parser_done  (parser_done),
      .dtype        (dtype),
      .operator     (operator),
      .src1         (src1),
      .src2         (src2),
      .alu_done     (alu_done),
      .enc_done     (enc_done),
      .alu_start    (alu_start),
      .alu_dtype    (alu_dtype),
      .alu_operator (alu_operator),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .busy         (busy),
      .fifo_level   (fifo_level),
      .ovf          (ovf),
      .tmo          (tmo),
      .drop_cnt     (drop_cnt),
      .fsm_state    (fsm_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ovf === 1'b1) ovf_seen++;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] d, input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
      dtype = d; operator = o; src1 = a; src2 = b;
      parser_done = 1'b1;
      tick();
      parser_done = 1'b0;
   endtask

   task automatic pulse_alu;
      alu_done = 1'b1; tick(); alu_done = 1'b0;
   endtask

   task automatic pulse_enc;
      enc_done = 1'b1; tick(); enc_done = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({alu_start, busy, fifo_level, ovf, tmo, drop_cnt, fsm_state} !== 16'h0 ||
          {alu_dtype, alu_operator, alu_src1, alu_src2} !== 41'h0) begin
         errors++;
         $display("FAIL reset_outputs: start=%b busy=%b lvl=%0d ovf=%b tmo=%b drops=%0d st=%0d fields=%h expected all zero",
                  alu_start, busy, fifo_level, ovf, tmo, drop_cnt, fsm_state, {alu_dtype, alu_operator, alu_src1, alu_src2});
      end
      tick();
      n_rst = 1'b1;
      tick();
      checks++;
      if ({alu_start, busy, fifo_level} !== 5'b0) begin
         errors++;
         $display("FAIL reset_release_idle: start=%b busy=%b lvl=%0d expected 0 0 0", alu_start, busy, fifo_level);
      end
   endtask

   task automatic test_single;
      send(4'd1, 5'd0, 16'd3, 16'd4);
      checks++;
      if ({fifo_level, alu_start, busy} !== {3'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_queued: lvl=%0d start=%b busy=%b expected 1 0 0", fifo_level, alu_start, busy);
      end
      tick();
      checks++;
      if (alu_start !== 1'b1 || {alu_dtype, alu_operator, alu_src1, alu_src2} !== {4'd1, 5'd0, 16'd3, 16'd4}) begin
         errors++;
         $display("FAIL single_start: start=%b src1=%0d src2=%0d op=%0d dt=%0d expected 1 3 4 0 1",
                  alu_start, alu_src1, alu_src2, alu_operator, alu_dtype);
      end
      tick();
      checks++;
      if ({alu_start, busy, fifo_level, fsm_state} !== {1'b0, 1'b1, 3'd0, 2'd2}) begin
         errors++;
         $display("FAIL single_wait_alu: start=%b busy=%b lvl=%0d st=%0d expected 0 1 0 2", alu_start, busy, fifo_level, fsm_state);
      end
      pulse_alu();
      tick();
      checks++;
      if ({busy, fsm_state, alu_start} !== {1'b1, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL single_wait_tx: busy=%b st=%0d start=%b expected 1 3 0", busy, fsm_state, alu_start);
      end
      pulse_enc();
      tick();
      checks++;
      if ({busy, fsm_state, alu_start, fifo_level} !== {1'b0, 2'd0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL single_done: busy=%b st=%0d start=%b lvl=%0d expected 0 0 0 0", busy, fsm_state, alu_start, fifo_level);
      end
   endtask

   task automatic test_burst;
      logic [15:0] e;
      for (int i = 0; i < 4; i++) begin
         send(4'd2, 5'd1, 16'(16 + i), 16'(32 + i));
         if (i == 1) begin
            checks++;
            if (alu_start !== 1'b1 || alu_src1 !== 16'd16 || alu_src2 !== 16'd32) begin
               errors++;
               $display("FAIL burst_first_start: start=%b src1=%0d src2=%0d expected 1 16 32", alu_start, alu_src1, alu_src2);
            end
         end
      end
      checks++;
      if (fifo_level !== 3'd3) begin
         errors++;
         $display("FAIL burst_level: lvl=%0d expected 3", fifo_level);
      end
      for (int i = 0; i < 4; i++) begin
         pulse_alu();
         pulse_enc();
         checks++;
         if (alu_start !== 1'b0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL burst_gap_%0d: start=%b st=%0d expected 0 0", i, alu_start, fsm_state);
         end
         tick();
         if (i < 3) begin
            e = 16'(17 + i);
            checks++;
            if (alu_start !== 1'b1 || alu_src1 !== e || alu_src2 !== 16'(e + 16)) begin
               errors++;
               $display("FAIL burst_start_%0d: start=%b src1=%0d src2=%0d expected 1 %0d %0d",
                        i + 1, alu_start, alu_src1, alu_src2, e, e + 16);
            end
            tick();
            checks++;
            if (fifo_level !== 3'(2 - i)) begin
               errors++;
               $display("FAIL burst_pop_%0d: lvl=%0d expected %0d", i + 1, fifo_level, 2 - i);
            end
         end else begin
            checks++;
            if ({alu_start, busy, fifo_level} !== 5'b0) begin
               errors++;
               $display("FAIL burst_drained: start=%b busy=%b lvl=%0d expected 0 0 0", alu_start, busy, fifo_level);
            end
         end
      end
      checks++;
      if (ovf_seen !== 0 || drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL burst_no_ovf: ovf_pulses=%0d drops=%0d expected 0 0", ovf_seen, drop_cnt);
      end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 6; i++) begin
         send(4'd3, 5'd2, 16'(32 + i), 16'(48 + i));
         if (i == 1) begin
            checks++;
            if (alu_start !== 1'b1 || alu_src1 !== 16'd32) begin
               errors++;
               $display("FAIL ovf_issue: start=%b src1=%0d expected 1 32", alu_start, alu_src1);
            end
         end
      end
      checks++;
      if ({ovf, drop_cnt, fifo_level, fsm_state} !== {1'b1, 8'd1, 3'd4, 2'd2}) begin
         errors++;
         $display("FAIL ovf_drop: ovf=%b drops=%0d lvl=%0d st=%0d expected 1 1 4 2", ovf, drop_cnt, fifo_level, fsm_state);
      end
      tick();
      checks++;
      if (ovf !== 1'b0 || drop_cnt !== 8'd1 || ovf_seen !== 1) begin
         errors++;
         $display("FAIL ovf_once: ovf=%b drops=%0d pulses=%0d expected 0 1 1", ovf, drop_cnt, ovf_seen);
      end
   endtask

   task automatic test_full_pop;
      pulse_alu();
      pulse_enc();
      checks++;
      if (fifo_level !== 3'd4 || alu_start !== 1'b0) begin
         errors++;
         $display("FAIL fullpop_pre: lvl=%0d start=%b expected 4 0", fifo_level, alu_start);
      end
      tick();
      checks++;
      if (alu_start !== 1'b1 || alu_src1 !== 16'd33 || fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL fullpop_issue: start=%b src1=%0d lvl=%0d expected 1 33 4", alu_start, alu_src1, fifo_level);
      end
      send(4'd4, 5'd4, 16'd64, 16'd65);
      checks++;
      if ({fifo_level, ovf, drop_cnt, fsm_state} !== {3'd4, 1'b0, 8'd1, 2'd2}) begin
         errors++;
         $display("FAIL fullpop_accept: lvl=%0d ovf=%b drops=%0d st=%0d expected 4 0 1 2", fifo_level, ovf, drop_cnt, fsm_state);
      end
   endtask

   task automatic test_watchdog;
      int early;
      early = 0;
      for (int j = 1; j < TIMEOUT; j++) begin
         if (tmo !== 1'b0) early++;
         tick();
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL wd_early: tmo high in %0d cycles expected 0", early);
      end
      checks++;
      if (tmo !== 1'b1 || fsm_state !== 2'd2) begin
         errors++;
         $display("FAIL wd_tmo: tmo=%b st=%0d expected 1 2", tmo, fsm_state);
      end
      tick();
      checks++;
      if ({tmo, fsm_state, alu_start, fifo_level} !== {1'b0, 2'd0, 1'b0, 3'd4}) begin
         errors++;
         $display("FAIL wd_idle: tmo=%b st=%0d start=%b lvl=%0d expected 0 0 0 4", tmo, fsm_state, alu_start, fifo_level);
      end
      tick();
      checks++;
      if (alu_start !== 1'b1 || alu_src1 !== 16'd34) begin
         errors++;
         $display("FAIL wd_next_issue: start=%b src1=%0d expected 1 34", alu_start, alu_src1);
      end
   endtask

   task automatic test_alu_done_wins;
      tick();
      pulse_enc();
      checks++;
      if (fsm_state !== 2'd2) begin
         errors++;
         $display("FAIL enc_ignored: st=%0d expected 2", fsm_state);
      end
      for (int j = 2; j < TIMEOUT; j++) tick();
      alu_done = 1'b1;
      #1;
      checks++;
      if (tmo !== 1'b0) begin
         errors++;
         $display("FAIL done_wins_tmo: tmo=%b expected 0", tmo);
      end
      tick();
      alu_done = 1'b0;
      checks++;
      if (fsm_state !== 2'd3 || tmo !== 1'b0) begin
         errors++;
         $display("FAIL done_wins_state: st=%0d tmo=%b expected 3 0", fsm_state, tmo);
      end
      pulse_alu();
      checks++;
      if (fsm_state !== 2'd3 || alu_start !== 1'b0) begin
         errors++;
         $display("FAIL alu_ignored: st=%0d start=%b expected 3 0", fsm_state, alu_start);
      end
   endtask

   task automatic test_reset_mid;
      int starts;
      pulse_enc();
      tick();
      checks++;
      if (alu_start !== 1'b1 || alu_src1 !== 16'd35) begin
         errors++;
         $display("FAIL rst_pre_issue: start=%b src1=%0d expected 1 35", alu_start, alu_src1);
      end
      tick();
      pulse_alu();
      checks++;
      if (fifo_level !== 3'd2 || fsm_state !== 2'd3) begin
         errors++;
         $display("FAIL rst_pre_state: lvl=%0d st=%0d expected 2 3", fifo_level, fsm_state);
      end
      #2 n_rst = 1'b0;
      #1;
      checks++;
      if ({alu_start, busy, fifo_level, ovf, tmo, drop_cnt, fsm_state} !== 16'h0 ||
          {alu_dtype, alu_operator, alu_src1, alu_src2} !== 41'h0) begin
         errors++;
         $display("FAIL rst_async: start=%b busy=%b lvl=%0d drops=%0d st=%0d fields=%h expected all zero",
                  alu_start, busy, fifo_level, drop_cnt, fsm_state, {alu_dtype, alu_operator, alu_src1, alu_src2});
      end
      tick();
      n_rst = 1'b1;
      starts = 0;
      for (int j = 0; j < 10; j++) begin
         tick();
         if (alu_start !== 1'b0 || busy !== 1'b0) starts++;
      end
      checks++;
      if (starts !== 0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL rst_quiet: active cycles=%0d lvl=%0d expected 0 0", starts, fifo_level);
      end
      send(4'd5, 5'd5, 16'd85, 16'd86);
      tick();
      checks++;
      if (alu_start !== 1'b1 || alu_src1 !== 16'd85 || alu_src2 !== 16'd86) begin
         errors++;
         $display("FAIL rst_recover: start=%b src1=%0d src2=%0d expected 1 85 86", alu_start, alu_src1, alu_src2);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_pop();
      test_watchdog();
      test_alu_done_wins();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_timeout: time limit reached before end of tests");
      $fatal(1, "time limit");
   end

endmodule
